regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with N combinational read ports, one synchronous write-back port and a per-register busy scoreboard for pipelined cores. It replaces the fixed 32x32, two-read-port file in the decode stage. Decode uses it to read operands and flag RAW hazards; write-back uses it to retire results. Register 0 is hardwired to zero.

## Interface
Parameters:
- XLEN, 32, data width in bits
- DEPTH, 32, number of architectural registers; power of two, >= 2
- NREAD, 2, number of read ports, 1..4
- AW, $clog2(DEPTH), register index width (derived, not overridden)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- rs_addr  in  NREAD*AW  packed read indices, port i at [i*AW +: AW]
- rs_data  out  NREAD*XLEN  packed read data, port i at [i*XLEN +: XLEN]
- rs_busy  out  NREAD  1 = port i's register has an outstanding write
- iss_en  in  1  issue strobe: an instruction writing iss_rd enters the pipe
- iss_rd  in  AW  destination of issued instruction
- wb_en  in  1  write-back strobe
- wb_rd  in  AW  write-back destination
- wb_data  in  XLEN  write-back value
- pend_cnt  out  AW+1  number of registers currently busy

## Operation
- Storage: DEPTH-1 registers of XLEN bits (index 0 not stored). Busy vector of DEPTH-1 bits. Counter pend_cnt.
- Read: rs_data[i] = reg[rs_addr[i]]; index 0 always returns 0, rs_busy = 0.
- Write: wb_en=1 and wb_rd!=0 -> reg[wb_rd] <= wb_data and busy[wb_rd] <= 0 at the edge. wb_rd=0 -> discarded, no state change.
- Issue: iss_en=1 and iss_rd!=0 -> busy[iss_rd] <= 1. iss_rd=0 ignored.
- Same edge, iss_rd == wb_rd (non-zero, both enabled): data written, busy ends 1 (set wins over clear).
- Issue to an already-busy register: busy stays 1, pend_cnt unchanged (legal WAW; the later write-back clears it).
- Write-back to a non-busy register: data written, busy stays 0, pend_cnt unchanged.
- pend_cnt = popcount(busy), maintained incrementally: +1 per 0->1 transition, -1 per 1->0, net 0 when both occur on different registers. Never wraps: max DEPTH-1 fits AW+1 bits.
- Reset low: all registers 0, all busy 0, pend_cnt 0, immediately (asynchronous); outputs reflect this while reset is low. Deassertion takes effect at the next rising edge.

## Timing
- Read path combinational, zero latency from rs_addr to rs_data/rs_busy.
- Write and busy updates visible on outputs the cycle after the strobe edge (default build).
- No handshake back-pressure; iss_en and wb_en accepted every cycle.
- Reset values: rs_data = 0, rs_busy = 0, pend_cnt = 0.

## Configuration
- REGFILE_BYPASS_EN defined: when wb_en=1, wb_rd!=0 and rs_addr[i]==wb_rd in the same cycle, rs_data[i] = wb_data and rs_busy[i] = 0 combinationally (write-first). If iss_en with iss_rd==wb_rd occurs in the same cycle, rs_busy[i] is still forced 0 (the reader consumes the retiring value).
- Not defined: reads return the stored value and stored busy bit; write-back visible one cycle later.

## Structure
- Shared package rv_pkg: XLEN default, REG_ZERO index constant, reg-index typedef used by decode and write-back.
- One sub-module: regfile_scoreboard (busy vector + pend_cnt, inputs iss/wb strobes, outputs busy vector and count); data array and read muxes stay in regfile_sb.

## Test plan
- Reset low mid-run after writing reg 5 = 0xDEADBEEF -> rs_data for reg 5 = 0 and pend_cnt = 0 immediately, before any edge.
- Write wb_rd=0, wb_data=0x1234 -> reading reg 0 returns 0, rs_busy=0, pend_cnt unchanged.
- Issue rd=7, then issue rd=9 -> pend_cnt 1 then 2, rs_busy high on ports reading 7/9; write-back rd=7 data 0x55 -> next cycle reg 7 = 0x55, busy 0, pend_cnt 1.
- Same edge issue rd=3 and write-back rd=3 data 0xA5 -> reg 3 = 0xA5, busy[3] = 1, pend_cnt +1.
- Read reg 4 while write-back to reg 4 = 0x77 (old 0x11): with REGFILE_BYPASS_EN -> 0x77, busy 0 same cycle; without -> 0x11 that cycle, 0x77 next.
- NREAD=4, DEPTH=16: all four ports read distinct registers 1,2,15,8 after writes 0x10,0x20,0xF0,0x80 -> correct values on each port slice.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared integer-register definitions for decode and write-back.
// Holds the default data width, the register-index type and the zero-register index.
package rv_pkg;

    localparam int RV_XLEN  = 32;
    localparam int RV_DEPTH = 32;
    localparam int RV_AW    = $clog2(RV_DEPTH);

    typedef logic [RV_AW-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with an incrementally maintained pending count.
// Latency: issue/write-back strobes visible on busy and pend_cnt one cycle later.
// Backpressure: none; both strobes are accepted every cycle.
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter  int DEPTH = RV_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_rd,
    output logic [DEPTH-1:1] busy,
    output logic [AW:0]      pend_cnt
);

    logic [DEPTH-1:1] busy_q;
    logic [DEPTH-1:1] busy_d;
    logic [DEPTH-1:0] busy_full;
    logic [AW:0]      cnt_q;
    logic             iss_hit;
    logic             wb_hit;
    logic             cnt_inc;
    logic             cnt_dec;

    assign busy_full = {busy_q, 1'b0};
    assign iss_hit   = iss_en && (iss_rd != AW'(REG_ZERO));
    assign wb_hit    = wb_en  && (wb_rd  != AW'(REG_ZERO));

    // A same-register issue keeps the bit set, so the retire must not count down.
    assign cnt_inc = iss_hit && !busy_full[iss_rd];
    assign cnt_dec = wb_hit && busy_full[wb_rd] && !(iss_hit && (iss_rd == wb_rd));

    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < DEPTH; r++) begin
            if (wb_hit && (wb_rd == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (iss_hit && (iss_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
        end
    end

    assign busy     = busy_q;
    assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file (r0 = 0) with NREAD combinational read ports and a busy scoreboard.
// Latency: reads zero-cycle; write-back visible next cycle, or same cycle with REGFILE_BYPASS_EN.
// Backpressure: none; iss_en and wb_en accepted every cycle.
module regfile_sb
    import rv_pkg::*;
#(
    parameter  int XLEN  = RV_XLEN,
    parameter  int DEPTH = RV_DEPTH,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic [AW:0]           pend_cnt
);

    logic [XLEN-1:0]  mem_q [DEPTH-1:1];
    logic [DEPTH-1:1] busy;
    logic [AW-1:0]    rd_idx;
    logic             wb_hit;

    assign wb_hit = wb_en && (wb_rd != AW'(REG_ZERO));

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .busy     (busy),
        .pend_cnt (pend_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else if (wb_hit) begin
            for (int r = 1; r < DEPTH; r++) begin
                if (wb_rd == AW'(r)) begin
                    mem_q[r] <= wb_data;
                end
            end
        end
    end

    // Index 0 matches no stored entry, so it falls through to the zero default.
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        rd_idx  = '0;
        for (int p = 0; p < NREAD; p++) begin
            rd_idx = rs_addr[p*AW +: AW];
            for (int r = 1; r < DEPTH; r++) begin
                if (rd_idx == AW'(r)) begin
                    rs_data[p*XLEN +: XLEN] = mem_q[r];
                    rs_busy[p]              = busy[r];
                end
            end
`ifdef REGFILE_BYPASS_EN
            // Write-first: the reader consumes the retiring value even if re-issued this cycle.
            if (wb_hit && (rd_idx == wb_rd)) begin
                rs_data[p*XLEN +: XLEN] = wb_data;
                rs_busy[p]              = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb (DEPTH=16, NREAD=4) against an array-based model.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int NREAD = 4;
    localparam int AW    = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREAD*AW-1:0]   rs_addr = '0;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD-1:0]      rs_busy;
    logic                  iss_en = 1'b0;
    logic [AW-1:0]         iss_rd = '0;
    logic                  wb_en = 1'b0;
    logic [AW-1:0]         wb_rd = '0;
    logic [XLEN-1:0]       wb_data = '0;
    logic [AW:0]           pend_cnt;

    logic [31:0] m_reg [DEPTH];
    bit          m_busy [DEPTH];
    int          n_checks = 0;
    int          n_fail = 0;

    regfile_sb #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .NREAD (NREAD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .pend_cnt (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_pending();
        int n = 0;
        for (int r = 0; r < DEPTH; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < DEPTH; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic drive(input logic ie, input logic [3:0] ir, input logic we, input logic [3:0] wr,
                         input logic [31:0] wd, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] a3);
        iss_en  = ie;
        iss_rd  = ir;
        wb_en   = we;
        wb_rd   = wr;
        wb_data = wd;
        rs_addr = {a3, a2, a1, a0};
    endtask

    task automatic check_model();
        logic [3:0]  a;
        logic [31:0] exp_d;
        logic        exp_b;
        for (int p = 0; p < NREAD; p++) begin
            a     = rs_addr[p*AW +: AW];
            exp_d = (a == 0) ? 32'h0 : m_reg[a];
            exp_b = (a == 0) ? 1'b0  : m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (wb_en && wb_rd != 0 && a == wb_rd) begin
                exp_d = wb_data;
                exp_b = 1'b0;
            end
`endif
            check($sformatf("port%0d_data_r%0d", p, a), rs_data[p*XLEN +: XLEN], exp_d);
            check($sformatf("port%0d_busy_r%0d", p, a), 32'(rs_busy[p]), 32'(exp_b));
        end
        check("pend_cnt", 32'(pend_cnt), 32'(model_pending()));
    endtask

    // Architectural effect of one rising edge: retire first, then issue so set wins.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            if (wb_en && wb_rd != 0) begin
                m_reg[wb_rd]  = wb_data;
                m_busy[wb_rd] = 1'b0;
            end
            if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic ie, input logic [3:0] ir, input logic we, input logic [3:0] wr,
                       input logic [31:0] wd, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] a2, input logic [3:0] a3);
        drive(ie, ir, we, wr, wd, a0, a1, a2, a3);
        #2;
        check_model();
        tick();
    endtask

    task automatic peek(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3);
        drive(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, a0, a1, a2, a3);
        #1;
    endtask

    initial begin
        model_clear();
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);

        peek(4'd1, 4'd2, 4'd15, 4'd8);
        check("reset_data", rs_data[31:0], 32'h0);
        check("reset_busy", 32'(rs_busy), 32'h0);
        check("reset_pend", 32'(pend_cnt), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-run, checked before any clock edge.
        cyc(1'b0, 4'd0, 1'b1, 4'd5, 32'hDEADBEEF, 4'd5, 4'd0, 4'd0, 4'd0);
        cyc(1'b1, 4'd6, 1'b0, 4'd0, 32'h0,        4'd5, 4'd6, 4'd0, 4'd0);
        peek(4'd5, 4'd6, 4'd0, 4'd0);
        check("pre_rst_r5", rs_data[31:0], 32'hDEADBEEF);
        check("pre_rst_pend", 32'(pend_cnt), 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_r5", rs_data[31:0], 32'h0);
        check("async_rst_pend", 32'(pend_cnt), 32'd0);
        model_clear();
        tick();
        reset = 1'b1;

        // Write-back to r0 is discarded.
        cyc(1'b0, 4'd0, 1'b1, 4'd0, 32'h1234, 4'd0, 4'd0, 4'd0, 4'd0);
        peek(4'd0, 4'd0, 4'd0, 4'd0);
        check("r0_data", rs_data[31:0], 32'h0);
        check("r0_busy", 32'(rs_busy[0]), 32'h0);
        check("r0_pend", 32'(pend_cnt), 32'd0);

        cyc(1'b1, 4'd7, 1'b0, 4'd0, 32'h0, 4'd7, 4'd9, 4'd0, 4'd0);
        peek(4'd7, 4'd9, 4'd0, 4'd0);
        check("iss7_pend", 32'(pend_cnt), 32'd1);
        check("iss7_busy", 32'(rs_busy[1:0]), 32'b01);
        cyc(1'b1, 4'd9, 1'b0, 4'd0, 32'h0, 4'd7, 4'd9, 4'd0, 4'd0);
        peek(4'd7, 4'd9, 4'd0, 4'd0);
        check("iss9_pend", 32'(pend_cnt), 32'd2);
        check("iss9_busy", 32'(rs_busy[1:0]), 32'b11);
        cyc(1'b0, 4'd0, 1'b1, 4'd7, 32'h55, 4'd7, 4'd9, 4'd0, 4'd0);
        peek(4'd7, 4'd9, 4'd0, 4'd0);
        check("wb7_data", rs_data[31:0], 32'h55);
        check("wb7_busy", 32'(rs_busy[1:0]), 32'b10);
        check("wb7_pend", 32'(pend_cnt), 32'd1);

        // Same-edge issue and retire on r3: data lands, busy set wins.
        cyc(1'b1, 4'd3, 1'b1, 4'd3, 32'hA5, 4'd3, 4'd0, 4'd0, 4'd0);
        peek(4'd3, 4'd0, 4'd0, 4'd0);
        check("same_r3_data", rs_data[31:0], 32'hA5);
        check("same_r3_busy", 32'(rs_busy[0]), 32'd1);
        check("same_r3_pend", 32'(pend_cnt), 32'd2);

        // Read during write-back of the same register.
        cyc(1'b0, 4'd0, 1'b1, 4'd4, 32'h11, 4'd0, 4'd0, 4'd0, 4'd0);
        drive(1'b0, 4'd0, 1'b1, 4'd4, 32'h77, 4'd4, 4'd0, 4'd0, 4'd0);
        #2;
        check_model();
`ifdef REGFILE_BYPASS_EN
        check("bypass_r4_same", rs_data[31:0], 32'h77);
`else
        check("nobypass_r4_same", rs_data[31:0], 32'h11);
`endif
        tick();
        peek(4'd4, 4'd0, 4'd0, 4'd0);
        check("r4_next", rs_data[31:0], 32'h77);
        check("r4_busy", 32'(rs_busy[0]), 32'd0);

        // Four ports on distinct registers.
        cyc(1'b0, 4'd0, 1'b1, 4'd1,  32'h10, 4'd0, 4'd0, 4'd0, 4'd0);
        cyc(1'b0, 4'd0, 1'b1, 4'd2,  32'h20, 4'd0, 4'd0, 4'd0, 4'd0);
        cyc(1'b0, 4'd0, 1'b1, 4'd15, 32'hF0, 4'd0, 4'd0, 4'd0, 4'd0);
        cyc(1'b0, 4'd0, 1'b1, 4'd8,  32'h80, 4'd0, 4'd0, 4'd0, 4'd0);
        peek(4'd1, 4'd2, 4'd15, 4'd8);
        check("port0_r1",  rs_data[31:0],   32'h10);
        check("port1_r2",  rs_data[63:32],  32'h20);
        check("port2_r15", rs_data[95:64],  32'hF0);
        check("port3_r8",  rs_data[127:96], 32'h80);

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
